// File: rtl/pot_scan_pkg.sv
// Shared constants for the pot scan controller: FSM state codes, slot count,
// slot-to-A2D-channel table and pot reset values.
package pot_scan_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned SLOT_W    = 3;
    localparam int unsigned CHNNL_W   = 3;
    localparam int unsigned POT_W     = 12;
    localparam int unsigned NUM_SLOTS = 6;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_GAP   = 3'd1;
    localparam logic [STATE_W-1:0] ST_START = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd3;
    localparam logic [STATE_W-1:0] ST_CAPT  = 3'd4;

    localparam logic [SLOT_W-1:0] SLOT_FIRST = 3'd0;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_SLOTS - 1);

    // Unity band gain for the EQ bands, mute for volume
    localparam logic [POT_W-1:0] POT_RST_BAND = 12'h800;
    localparam logic [POT_W-1:0] POT_RST_VOL  = 12'h000;

    // Slot order LP, B1, B2, B3, HP, VOL mapped onto the A2D mux channels
    function automatic logic [CHNNL_W-1:0] slot_chnnl(input logic [SLOT_W-1:0] slot);
        logic [CHNNL_W-1:0] ch;
        case (slot)
            3'd0:    ch = 3'd1;
            3'd1:    ch = 3'd0;
            3'd2:    ch = 3'd4;
            3'd3:    ch = 3'd2;
            3'd4:    ch = 3'd3;
            3'd5:    ch = 3'd7;
            default: ch = 3'd1;
        endcase
        return ch;
    endfunction

    function automatic logic [POT_W-1:0] pot_rst_val(input logic [SLOT_W-1:0] slot);
        return (slot == SLOT_LAST) ? POT_RST_VOL : POT_RST_BAND;
    endfunction

endpackage

// File: rtl/pot_scan_ctrl.sv
// Round-robin A2D scanner for the six equalizer pots.
// Optional build macro POT_SMOOTH_EN: pot registers take the rounded average
// of old value and new sample instead of the raw sample.
module pot_scan_ctrl
    import pot_scan_pkg::*;
#(
    parameter int unsigned GAP_CYC = 8,
    parameter int unsigned TMO_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_en,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic [11:0] LP_pot,
    output logic [11:0] B1_pot,
    output logic [11:0] B2_pot,
    output logic [11:0] B3_pot,
    output logic [11:0] HP_pot,
    output logic [11:0] VOL_pot,
    output logic        scan_done,
    output logic        tmo_err
);

    localparam int unsigned GAP_W = 8;
    localparam int unsigned TMO_W = 12;

    logic [STATE_W-1:0] state, state_nxt;
    logic [SLOT_W-1:0]  slot, slot_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic [POT_W-1:0]   cap;
    logic [POT_W-1:0]   pot [NUM_SLOTS];
    logic [POT_W-1:0]   pot_upd;
    logic               cap_ld, pot_wr, tmo_hit, conv_end;

    // Next-state, counter and strobe decode
    always_comb begin
        state_nxt   = state;
        slot_nxt    = slot;
        gap_cnt_nxt = gap_cnt;
        tmo_cnt_nxt = tmo_cnt;
        cap_ld      = 1'b0;
        pot_wr      = 1'b0;
        tmo_hit     = 1'b0;
        conv_end    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (scan_en) begin
                    state_nxt   = ST_GAP;
                    gap_cnt_nxt = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    state_nxt   = ST_START;
                    gap_cnt_nxt = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            ST_START: begin
                state_nxt   = ST_WAIT;
                tmo_cnt_nxt = '0;
            end
            ST_WAIT: begin
                if (cnv_cmplt) begin
                    cap_ld      = 1'b1;
                    state_nxt   = ST_CAPT;
                    tmo_cnt_nxt = '0;
                end else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                    tmo_hit  = 1'b1;
                    conv_end = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            ST_CAPT: begin
                pot_wr   = 1'b1;
                conv_end = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A finished (or timed-out) conversion advances the slot; scan_en decides GAP vs IDLE
        if (conv_end) begin
            slot_nxt    = (slot == SLOT_LAST) ? SLOT_FIRST : slot + SLOT_W'(1);
            state_nxt   = scan_en ? ST_GAP : ST_IDLE;
            gap_cnt_nxt = '0;
            tmo_cnt_nxt = '0;
        end
    end

    // FSM, counters and registered control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            slot      <= SLOT_FIRST;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            cap       <= '0;
            strt_cnv  <= 1'b0;
            chnnl     <= slot_chnnl(SLOT_FIRST);
            scan_done <= 1'b0;
            tmo_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            slot      <= slot_nxt;
            gap_cnt   <= gap_cnt_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            strt_cnv  <= (state_nxt == ST_START);
            chnnl     <= slot_chnnl(slot_nxt);
            scan_done <= conv_end && (slot == SLOT_LAST);
            if (tmo_hit) begin
                tmo_err <= 1'b1;
            end
            if (cap_ld) begin
                cap <= res;
            end
        end
    end

`ifdef POT_SMOOTH_EN
    logic [POT_W:0] smooth_sum;
    // Rounded average of old pot value and new sample, one extra bit for the carry
    assign smooth_sum = (POT_W+1)'(pot[slot]) + (POT_W+1)'(cap) + (POT_W+1)'(1);
    assign pot_upd    = POT_W'(smooth_sum >> 1);
`else
    assign pot_upd = cap;
`endif

    // Pot registers, written only from CAPT so a timeout leaves them untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pot[i] <= pot_rst_val(SLOT_W'(i));
            end
        end else if (pot_wr) begin
            pot[slot] <= pot_upd;
        end
    end

    assign LP_pot  = pot[0];
    assign B1_pot  = pot[1];
    assign B2_pot  = pot[2];
    assign B3_pot  = pot[3];
    assign HP_pot  = pot[4];
    assign VOL_pot = pot[5];

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Directed bench for pot_scan_ctrl: sweep, spurious strobe, timeout,
// stop/resume, mid-conversion reset and pot update arithmetic.
module tb_pot_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_en = 1'b0;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res = 12'h000;
    logic        strt_cnv, scan_done, tmo_err;
    logic [2:0]  chnnl;
    logic [11:0] LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot;

    int n_run  = 0;
    int n_fail = 0;
    int sd_cnt = 0;

    logic [2:0]  ch_tab [0:5] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    logic [11:0] m_pot  [0:5];

    pot_scan_ctrl #(.GAP_CYC(8), .TMO_CYC(1023)) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
        .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .res(res),
        .LP_pot(LP_pot), .B1_pot(B1_pot), .B2_pot(B2_pot),
        .B3_pot(B3_pot), .HP_pot(HP_pot), .VOL_pot(VOL_pot),
        .scan_done(scan_done), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (scan_done === 1'b1) sd_cnt <= sd_cnt + 1;

    function automatic logic [11:0] get_pot(input int s);
        case (s)
            0: return LP_pot;
            1: return B1_pot;
            2: return B2_pot;
            3: return B3_pot;
            4: return HP_pot;
            default: return VOL_pot;
        endcase
    endfunction

    function automatic logic [11:0] upd(input logic [11:0] old, input logic [11:0] r);
`ifdef POT_SMOOTH_EN
        logic [12:0] s;
        s = {1'b0, old} + {1'b0, r} + 13'd1;
        return s[12:1];
`else
        return r;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 6; i++) m_pot[i] = (i == 5) ? 12'h000 : 12'h800;
    endtask

    task automatic chk_pots(input string tag);
        for (int i = 0; i < 6; i++) chk($sformatf("%s_pot%0d", tag, i), 32'(get_pot(i)), 32'(m_pot[i]));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_strt"}, 32'(strt_cnv), 32'd0);
        chk({tag, "_chnnl"}, 32'(chnnl), 32'd1);
        chk({tag, "_done"}, 32'(scan_done), 32'd0);
        chk({tag, "_tmo"}, 32'(tmo_err), 32'd0);
        chk_pots(tag);
    endtask

    // Waits (bounded) for a start pulse, checks its channel and single-cycle width
    task automatic wait_strt(input string tag, input logic [2:0] exp_ch);
        bit found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (strt_cnv === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_strt_seen"}, 32'(found), 32'd1);
        chk({tag, "_chnnl"}, 32'(chnnl), 32'(exp_ch));
        step();
        if (found) chk({tag, "_strt_1cyc"}, 32'(strt_cnv), 32'd0);
    endtask

    // One conversion answered 20 cycles after strt_cnv; optional scan_en drop mid-WAIT
    task automatic conv(input int s, input logic [11:0] r, input bit drop);
        string tag = $sformatf("slot%0d", s);
        wait_strt(tag, ch_tab[s]);
        repeat (18) begin
            step();
            if (drop) scan_en = 1'b0;
        end
        chk({tag, "_chnnl_hold"}, 32'(chnnl), 32'(ch_tab[s]));
        cnv_cmplt = 1'b1;
        res       = r;
        step();
        cnv_cmplt = 1'b0;
        res       = 12'h000;
        step();
        m_pot[s] = upd(m_pot[s], r);
        chk({tag, "_pot"}, 32'(get_pot(s)), 32'(m_pot[s]));
    endtask

    initial begin
        int sd0, n, nstrt;
        model_reset();

        // Reset state
        repeat (3) step();
        chk_reset("rst");
        rst_n = 1'b1;

        // Single sweep, res = 0x100 + slot
        scan_en = 1'b1;
        sd0 = sd_cnt;
        for (int s = 0; s < 6; s++) conv(s, 12'h100 + 12'(s), 1'b0);
        chk("sweep_done_pulse", 32'(scan_done), 32'd1);
`ifndef POT_SMOOTH_EN
        chk("sweep_lp", 32'(LP_pot), 32'h100);
        chk("sweep_vol", 32'(VOL_pot), 32'h105);
`endif

        // Spurious strobe during GAP
        cnv_cmplt = 1'b1;
        res       = 12'hFFF;
        step();
        cnv_cmplt = 1'b0;
        res       = 12'h000;
        repeat (3) step();
        chk_pots("spur");
        chk("sweep_done_count", 32'(sd_cnt - sd0), 32'd1);
        chk("spur_next_ch", 32'(chnnl), 32'd1);

        // Timeout on slot 2 from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        chk("tmo_rst", 32'(tmo_err), 32'd0);
        conv(0, 12'h200, 1'b0);
        conv(1, 12'h201, 1'b0);
        wait_strt("tmo", 3'd4);
        n = 1;
        while (tmo_err !== 1'b1 && n < 1200) begin
            step();
            n++;
        end
        chk("tmo_latency", 32'(n), 32'd1024);
        chk("tmo_b2_kept", 32'(B2_pot), 32'h800);

        // Slot 3 with scan_en dropped in WAIT: capture completes, then idle
        conv(3, 12'h303, 1'b1);
        chk("tmo_sticky", 32'(tmo_err), 32'd1);
        nstrt = 0;
        repeat (100) begin
            step();
            if (strt_cnv === 1'b1) nstrt++;
        end
        chk("stop_no_strt", 32'(nstrt), 32'd0);
        chk("stop_ch_kept", 32'(chnnl), 32'd3);

        // Resume at slot 4, then reset in the middle of its WAIT
        scan_en = 1'b1;
        wait_strt("resume", 3'd3);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        model_reset();
        chk_reset("midrst");
        rst_n     = 1'b1;
        cnv_cmplt = 1'b1;
        res       = 12'hABC;
        step();
        cnv_cmplt = 1'b0;
        res       = 12'h000;
        repeat (3) step();
        chk_pots("late_cmplt");

        // Update arithmetic on LP: res 000 then 001
        conv(0, 12'h000, 1'b0);
`ifdef POT_SMOOTH_EN
        chk("upd_lp_a", 32'(LP_pot), 32'h400);
`else
        chk("upd_lp_a", 32'(LP_pot), 32'h000);
`endif
        for (int s = 1; s < 6; s++) conv(s, 12'h050 * 12'(s), 1'b0);
        conv(0, 12'h001, 1'b0);
`ifdef POT_SMOOTH_EN
        chk("upd_lp_b", 32'(LP_pot), 32'h201);
`else
        chk("upd_lp_b", 32'(LP_pot), 32'h001);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
